// File: rtl/bus_slave_regs.sv
// Bring-up bus responder: latches one strobed access, inserts WAIT_CYCLES wait
// states, then returns a one-cycle active-low rdy_ with registered read data.
module bus_slave_regs #(
    parameter int          REG_AW      = 3,
    parameter int          WAIT_CYCLES = 1,
    parameter logic [31:0] ID_VALUE    = 32'h5843_5330,
    parameter logic [31:0] CYCLE_INIT  = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cs_,
    input  logic        as_,
    input  logic        rw,
    input  logic [31:0] addr,
    input  logic [31:0] wr_data,
    output logic [31:0] rd_data,
    output logic        rdy_
);
    localparam int NUM_REGS = 1 << REG_AW;
    localparam logic [3:0] WAIT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

    typedef enum logic [1:0] {IDLE, WAIT, ACK} state_t;

    state_t             state, state_nxt;
    logic [3:0]         wait_cnt;
    logic               req, accept, overrun;
    logic [REG_AW-1:0]  req_idx;
    logic               req_rw;
    logic [31:0]        req_wdata;
    logic [31:0]        cycle_cnt;
    logic               ovr;
    logic [31:0]        scratch [3:NUM_REGS-1];
    logic               do_ack, do_write;
    logic [31:0]        rd_mux;
    logic               unused_addr;

    assign unused_addr = ^{addr[31:REG_AW+2], addr[1:0]};

    assign req     = !as_ && !cs_;
    assign accept  = req && (state == IDLE);
    assign overrun = req && (state != IDLE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = (WAIT_CYCLES > 0) ? WAIT : ACK;
            WAIT:    if (wait_cnt == 4'd0) state_nxt = ACK;
            ACK:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // ACK is the cycle in which the access resolves; the registered rdy_/rd_data
    // show it on the following cycle, so the FSM is already IDLE while rdy_ is low.
    always_comb begin
        do_ack   = (state == ACK);
        do_write = do_ack && !req_rw;
        rd_mux   = 32'h0;
        case (req_idx)
            REG_AW'(0): rd_mux = ID_VALUE;
            REG_AW'(1): rd_mux = cycle_cnt;
            REG_AW'(2): rd_mux = {31'h0, ovr};
            default: begin
                for (int i = 3; i < NUM_REGS; i++)
                    if (req_idx == REG_AW'(i)) rd_mux = scratch[i];
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wait_cnt  <= 4'd0;
            req_idx   <= '0;
            req_rw    <= 1'b0;
            req_wdata <= 32'h0;
        end else if (accept) begin
            wait_cnt  <= WAIT_LOAD;
            req_idx   <= addr[REG_AW+1:2];
            req_rw    <= rw;
            req_wdata <= wr_data;
        end else if (state == WAIT && wait_cnt != 4'd0) begin
            wait_cnt  <= wait_cnt - 4'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) cycle_cnt <= CYCLE_INIT;
        else       cycle_cnt <= cycle_cnt + 32'd1;
    end

    // A fresh overrun beats a simultaneous write-one-to-clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)                                                ovr <= 1'b0;
        else if (overrun)                                         ovr <= 1'b1;
        else if (do_write && req_idx == REG_AW'(2) && req_wdata[0]) ovr <= 1'b0;
    end

    always_ff @(posedge clk or posedge reset) begin
        for (int i = 3; i < NUM_REGS; i++) begin
            if (reset)                                    scratch[i] <= 32'h0;
            else if (do_write && req_idx == REG_AW'(i))   scratch[i] <= req_wdata;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rdy_    <= 1'b1;
            rd_data <= 32'h0;
        end else begin
            rdy_    <= !do_ack;
            rd_data <= (do_ack && req_rw) ? rd_mux : 32'h0;
        end
    end
endmodule

// File: tb/tb_bus_slave_regs.sv
// Scoreboard bench: two responders (WAIT_CYCLES 1 and 0) on a shared bus; a
// transaction-level model predicts each ack edge and data, a monitor checks them.
module tb_bus_slave_regs;
    localparam logic [31:0] ID    = 32'h5843_5330;
    localparam logic [31:0] INIT1 = 32'hFFFF_FFF8;

    logic        clk = 1'b0, reset = 1'b1, as_ = 1'b1, rw = 1'b1;
    logic [1:0]  cs_ = 2'b11;
    logic [31:0] addr = 32'h0, wr_data = 32'h0;
    logic [31:0] rd0, rd1;
    logic        rdy0, rdy1;

    always #5 clk = ~clk;

    bus_slave_regs #(.REG_AW(3), .WAIT_CYCLES(1), .ID_VALUE(ID)) dut0 (
        .clk(clk), .reset(reset), .cs_(cs_[0]), .as_(as_), .rw(rw), .addr(addr),
        .wr_data(wr_data), .rd_data(rd0), .rdy_(rdy0));
    bus_slave_regs #(.REG_AW(3), .WAIT_CYCLES(0), .ID_VALUE(ID), .CYCLE_INIT(INIT1)) dut1 (
        .clk(clk), .reset(reset), .cs_(cs_[1]), .as_(as_), .rw(rw), .addr(addr),
        .wr_data(wr_data), .rd_data(rd1), .rdy_(rdy1));

    // Rising edges since reset release; the DUT cycle counter equals INIT + edges.
    int unsigned edges = 0;
    always @(posedge clk or posedge reset)
        if (reset) edges <= 0;
        else       edges <= edges + 1;

    typedef struct { int unsigned cyc; logic [31:0] data; } exp_t;
    exp_t q0[$], q1[$];
    int errors = 0, checks = 0;

    logic [31:0] mregs [2][8];
    bit          movr [2];
    int unsigned nfree [2];
    bit          pv [2];
    int unsigned pk [2];
    bit          prw [2];
    int          pidx [2];
    logic [31:0] pdat [2];

    function automatic int unsigned wc(input int d);
        return (d == 0) ? 1 : 0;
    endfunction

    function automatic logic [31:0] init_of(input int d);
        return (d == 0) ? 32'h0 : INIT1;
    endfunction

    task automatic push(input int d, input exp_t x);
        if (d == 0) q0.push_back(x); else q1.push_back(x);
    endtask

    // Resolve the pending access at its ack edge: reads see pre-edge state, writes commit.
    task automatic retire(input int d);
        exp_t x;
        x.cyc  = pk[d] + 1 + wc(d);
        x.data = 32'h0;
        if (prw[d]) begin
            case (pidx[d])
                0:       x.data = ID;
                1:       x.data = init_of(d) + x.cyc - 1;
                2:       x.data = {31'h0, movr[d]};
                default: x.data = mregs[d][pidx[d]];
            endcase
        end else if (pidx[d] == 2) begin
            if (pdat[d][0]) movr[d] = 1'b0;
        end else if (pidx[d] >= 3) begin
            mregs[d][pidx[d]] = pdat[d];
        end
        push(d, x);
        pv[d] = 1'b0;
    endtask

    task automatic retire_due();
        for (int d = 0; d < 2; d++)
            if (pv[d] && pk[d] + 1 + wc(d) <= edges) retire(d);
    endtask

    task automatic model_strobe(input int d, input bit r, input int idx, input logic [31:0] wd);
        int unsigned e;
        e = edges + 1;
        if (e < nfree[d]) begin
            if (pv[d] && pk[d] + 1 + wc(d) == e) retire(d);
            movr[d] = 1'b1;
        end else begin
            pv[d] = 1'b1; pk[d] = e; prw[d] = r; pidx[d] = idx; pdat[d] = wd;
            nfree[d] = e + 2 + wc(d);
        end
    endtask

    // One bus cycle, called at a falling edge; idle cycles carry junk on the bus.
    task automatic step(input int d, input bit s, input bit r, input int idx, input logic [31:0] wd);
        retire_due();
        as_ = 1'b1; cs_ = 2'b11; rw = 1'($urandom); addr = $urandom; wr_data = $urandom;
        if (s) begin
            as_ = 1'b0; cs_[d] = 1'b0; rw = r; wr_data = wd;
            addr = ($urandom & 32'hFFFF_FFE3) | (32'(idx) << 2);
            model_strobe(d, r, idx, wd);
        end else if ($urandom_range(0, 7) == 0) begin
            as_ = 1'b0;
        end
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 1'b0, 1'b0, 0, 32'h0);
    endtask

    task automatic do_reset(input int n);
        reset = 1'b1; as_ = 1'b1; cs_ = 2'b11;
        for (int d = 0; d < 2; d++) begin
            pv[d] = 1'b0; movr[d] = 1'b0; nfree[d] = 0;
            for (int i = 0; i < 8; i++) mregs[d][i] = 32'h0;
        end
        q0.delete(); q1.delete();
        repeat (n) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic chk(input int d, input logic r, input logic [31:0] rd);
        exp_t x;
        int   n;
        n = (d == 0) ? q0.size() : q1.size();
        checks++;
        if (r !== 1'b1) begin
            if (n == 0) begin
                errors++;
                $display("FAIL spurious_rdy dut%0d: got rdy_=%b data %h at edge %0d, required no ack", d, r, rd, edges);
            end else begin
                x = (d == 0) ? q0.pop_front() : q1.pop_front();
                if (x.cyc != edges || rd !== x.data) begin
                    errors++;
                    $display("FAIL ack dut%0d: got edge %0d data %h, required edge %0d data %h", d, edges, rd, x.cyc, x.data);
                end
            end
        end else begin
            if (n != 0) begin
                x = (d == 0) ? q0[0] : q1[0];
                if (x.cyc <= edges) begin
                    errors++;
                    $display("FAIL missing_ack dut%0d: got rdy_=1 at edge %0d, required ack data %h", d, edges, x.data);
                    if (d == 0) void'(q0.pop_front()); else void'(q1.pop_front());
                end
            end
            if (rd !== 32'h0) begin
                errors++;
                $display("FAIL idle_data dut%0d: got %h with rdy_ high, required 0", d, rd);
            end
        end
    endtask

    always begin
        @(negedge clk);
        #1;
        chk(0, rdy0, rd0);
        chk(1, rdy1, rd1);
    end

    initial begin
        do_reset(3);
        // CYCLE wraps through zero between two reads spaced 10 strobes apart
        step(1, 1, 1, 1, 0); idle(9);
        step(1, 1, 1, 1, 0); idle(3);
        // ID read with one wait state, scratch write/read, ignored ID write
        step(0, 1, 1, 0, 0); idle(4);
        step(0, 1, 0, 3, 32'hDEAD_BEEF); idle(3);
        step(0, 1, 1, 3, 0); idle(3);
        step(0, 1, 0, 0, 32'h1234_5678); idle(3);
        step(0, 1, 1, 0, 0); idle(3);
        // overruns in WAIT and in the resolving cycle, then STATUS W1C
        step(0, 1, 1, 4, 0); step(0, 1, 1, 5, 0); step(0, 1, 0, 6, 32'h1); idle(2);
        step(0, 1, 1, 2, 0); idle(3);
        step(0, 1, 0, 2, 32'h1); idle(3);
        step(0, 1, 1, 2, 0); idle(3);
        // W1C lands on the same edge as a new overrun: OVR stays set
        step(0, 1, 0, 2, 32'hFFFF_FFFF); idle(1); step(0, 1, 1, 0, 0); idle(3);
        step(0, 1, 1, 2, 0); idle(3);
        step(0, 1, 0, 2, 32'h1); idle(3);
        // back-to-back on the one-wait responder
        step(0, 1, 0, 7, 32'hA5A5_0001); idle(2); step(0, 1, 1, 7, 0); idle(3);
        // zero-wait responder, strobes two cycles apart
        step(1, 1, 0, 5, 32'h0BAD_F00D); idle(1);
        step(1, 1, 1, 5, 0); idle(1);
        step(1, 1, 1, 2, 0); idle(3);
        // reset during WAIT drops the write
        step(0, 1, 0, 4, 32'hAAAA_5555);
        do_reset(3);
        step(0, 1, 1, 4, 0); idle(4);
        for (int i = 0; i < 800; i++)
            step($urandom_range(0, 1), $urandom_range(0, 2) != 0, 1'($urandom),
                 $urandom_range(0, 7), $urandom);
        idle(8);
        checks++;
        if (q0.size() != 0 || q1.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d/%0d outstanding acks, required 0/0", q0.size(), q1.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
